// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback register file slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package wb_regfile_pkg;

    localparam int REG_NUM = 32;  // number of general-purpose registers
    localparam int ADDR_W  = 5;   // GPR address width
    localparam int DATA_W  = 32;  // GPR / HI / LO data width

    typedef logic [ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [DATA_W-1:0] reg_bus_t;

    localparam reg_bus_t      ZERO_WORD     = '0;
    localparam reg_addr_bus_t NOP_REG_ADDR  = '0;     // r0, hardwired to zero
    localparam logic          WRITE_ENABLE  = 1'b1;
    localparam logic          WRITE_DISABLE = 1'b0;
    localparam logic          READ_ENABLE   = 1'b1;
    localparam logic          READ_DISABLE  = 1'b0;
    localparam logic          RST_ENABLE    = 1'b0;   // reset is active-low

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair with async reset and same-cycle write-through bypass.
// Latency: write visible on hi_o/lo_o in the write cycle (bypass), stored from the next cycle.
// Backpressure: none; a write is always accepted.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   wb_whilo          write enable for both halves
//   wb_hi, wb_lo      write data
//   hi_o, lo_o        stored or bypassed HI/LO, forced to zero while in reset
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    reg_bus_t hi_q;
    reg_bus_t lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else if (wb_whilo == WRITE_ENABLE) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    always_comb begin
        hi_o = ZERO_WORD;
        lo_o = ZERO_WORD;
        if (rst == RST_ENABLE) begin
            hi_o = ZERO_WORD;
            lo_o = ZERO_WORD;
        end else if (wb_whilo == WRITE_DISABLE) begin
            hi_o = hi_q;
            lo_o = lo_q;
        end else begin
            // EX reads the value being committed this cycle
            hi_o = wb_hi;
            lo_o = wb_lo;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback register file: commits MEM/WB bundle into 32x32 GPRs and HI/LO, serves ID/EX reads.
// Latency: reads combinational; writes visible via bypass same cycle, from storage next cycle.
// Backpressure: none; every writeback is accepted unconditionally.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   wb_wd/wb_wreg/wb_wdata        GPR write address/enable/data
//   wb_whilo/wb_hi/wb_lo          HI/LO write enable and data
//   re1/raddr1/rdata1             GPR read port 1
//   re2/raddr2/rdata2             GPR read port 2
//   hi_o/lo_o                     HI/LO read port (bypassed)
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    reg_bus_t gpr [REG_NUM];

    // r0 is never written so it reads back as zero from storage as well
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr[i] <= ZERO_WORD;
            end
        end else if (wb_wreg == WRITE_ENABLE && wb_wd != NOP_REG_ADDR) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    // Priority: reset, r0, disabled port, bypass from writeback, storage.
    // The r0 check precedes the bypass so a discarded write to r0 never leaks through.
    always_comb begin
        rdata1 = ZERO_WORD;
        if (rst == RST_ENABLE) begin
            rdata1 = ZERO_WORD;
        end else if (raddr1 == NOP_REG_ADDR) begin
            rdata1 = ZERO_WORD;
        end else if (re1 == READ_DISABLE) begin
            rdata1 = ZERO_WORD;
        end else if (wb_wreg == WRITE_ENABLE && wb_wd == raddr1) begin
            rdata1 = wb_wdata;
        end else begin
            rdata1 = gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = ZERO_WORD;
        if (rst == RST_ENABLE) begin
            rdata2 = ZERO_WORD;
        end else if (raddr2 == NOP_REG_ADDR) begin
            rdata2 = ZERO_WORD;
        end else if (re2 != READ_ENABLE) begin
            rdata2 = ZERO_WORD;
        end else if (wb_wreg == WRITE_ENABLE && wb_wd == raddr2) begin
            rdata2 = wb_wdata;
        end else begin
            rdata2 = gpr[raddr2];
        end
    end

    hilo_reg u_hilo_reg (
        .clk      (clk),
        .rst      (rst),
        .wb_whilo (wb_whilo),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, bypass, r0, HI/LO, back-to-back, async reset.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_whilo (wb_whilo),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    // advance to just after the next rising edge; inputs change here, outputs sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        wb_wreg  = 1'b0;
        wb_wd    = 5'd0;
        wb_wdata = 32'h0;
        wb_whilo = 1'b0;
        wb_hi    = 32'h0;
        wb_lo    = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_wb();
        re1 = 1'b1; raddr1 = 5'd3;
        re2 = 1'b1; raddr2 = 5'd7;
        // writes presented during reset must neither show nor commit
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hCAFE_0003;
        wb_whilo = 1'b1; wb_hi = 32'h1111_2222; wb_lo = 32'h3333_4444;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=%h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=%h", rdata2, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'h0); end
        tick();
        tick();
        idle_wb();
        #2;
        rst = 1'b1;  // released between edges
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = a[4:0];
            raddr2 = a[4:0];
            #1;
            checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_sweep1 addr=%0d got=%h exp=%h", a, rdata1, 32'h0); end
            checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_sweep2 addr=%0d got=%h exp=%h", a, rdata2, 32'h0); end
        end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL post_reset_hi got=%h exp=%h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL post_reset_lo got=%h exp=%h", lo_o, 32'h0); end
    endtask

    task automatic test_write_read();
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd1;
        tick();
        idle_wb();
        raddr1 = 5'd5;
        #1;
        checks++; if (rdata1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_read got=%h exp=%h", rdata1, 32'hDEAD_BEEF); end
        re1 = 1'b0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL read_disabled got=%h exp=%h", rdata1, 32'h0); end
        re1 = 1'b1;
    endtask

    task automatic test_bypass();
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h1234_5678;
        re1 = 1'b1; raddr1 = 5'd9;
        re2 = 1'b1; raddr2 = 5'd9;
        #1;
        checks++; if (rdata1 !== 32'h1234_5678) begin failures++; $display("FAIL bypass1 got=%h exp=%h", rdata1, 32'h1234_5678); end
        checks++; if (rdata2 !== 32'h1234_5678) begin failures++; $display("FAIL bypass2 got=%h exp=%h", rdata2, 32'h1234_5678); end
        tick();
        idle_wb();
        #1;
        checks++; if (rdata1 !== 32'h1234_5678) begin failures++; $display("FAIL stored1 got=%h exp=%h", rdata1, 32'h1234_5678); end
        checks++; if (rdata2 !== 32'h1234_5678) begin failures++; $display("FAIL stored2 got=%h exp=%h", rdata2, 32'h1234_5678); end
        // disabled port must not bypass either
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h5555_AAAA;
        re2 = 1'b0;
        #1;
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL bypass_disabled got=%h exp=%h", rdata2, 32'h0); end
        idle_wb();
        re2 = 1'b1;
    endtask

    task automatic test_zero_reg();
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        re2 = 1'b1; raddr2 = 5'd0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL r0_during_write got=%h exp=%h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL r0_during_write2 got=%h exp=%h", rdata2, 32'h0); end
        tick();
        idle_wb();
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL r0_after_write got=%h exp=%h", rdata1, 32'h0); end
    endtask

    task automatic test_hilo();
        tick();
        wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_BBBB;
        wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'h0000_0011;
        raddr1 = 5'd4;
        #1;
        checks++; if (hi_o !== 32'hAAAA_0000) begin failures++; $display("FAIL hi_bypass got=%h exp=%h", hi_o, 32'hAAAA_0000); end
        checks++; if (lo_o !== 32'h0000_BBBB) begin failures++; $display("FAIL lo_bypass got=%h exp=%h", lo_o, 32'h0000_BBBB); end
        checks++; if (rdata1 !== 32'h0000_0011) begin failures++; $display("FAIL gpr4_bypass got=%h exp=%h", rdata1, 32'h11); end
        tick();
        idle_wb();
        wb_hi = 32'h9999_9999; wb_lo = 32'h8888_8888;  // ignored without wb_whilo
        #1;
        checks++; if (hi_o !== 32'hAAAA_0000) begin failures++; $display("FAIL hi_held got=%h exp=%h", hi_o, 32'hAAAA_0000); end
        checks++; if (lo_o !== 32'h0000_BBBB) begin failures++; $display("FAIL lo_held got=%h exp=%h", lo_o, 32'h0000_BBBB); end
        checks++; if (rdata1 !== 32'h0000_0011) begin failures++; $display("FAIL gpr4_stored got=%h exp=%h", rdata1, 32'h11); end
        tick();
        #1;
        checks++; if (hi_o !== 32'hAAAA_0000) begin failures++; $display("FAIL hi_not_written got=%h exp=%h", hi_o, 32'hAAAA_0000); end
        idle_wb();
    endtask

    task automatic test_back_to_back();
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd6; wb_wdata = 32'h0000_000A;
        raddr1 = 5'd6;
        raddr2 = 5'd5;
        #1;
        checks++; if (rdata1 !== 32'h0000_000A) begin failures++; $display("FAIL b2b_first got=%h exp=%h", rdata1, 32'hA); end
        checks++; if (rdata2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_other_port got=%h exp=%h", rdata2, 32'hDEAD_BEEF); end
        tick();
        wb_wdata = 32'h0000_000B;
        #1;
        checks++; if (rdata1 !== 32'h0000_000B) begin failures++; $display("FAIL b2b_second got=%h exp=%h", rdata1, 32'hB); end
        tick();
        idle_wb();
        #1;
        checks++; if (rdata1 !== 32'h0000_000B) begin failures++; $display("FAIL b2b_last_wins got=%h exp=%h", rdata1, 32'hB); end
    endtask

    task automatic test_async_reset();
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd1; wb_wdata = 32'h0000_0001;
        tick();
        wb_wd = 5'd31; wb_wdata = 32'h0000_001F;
        wb_whilo = 1'b1; wb_hi = 32'h0000_0005; wb_lo = 32'h0000_0000;
        tick();
        idle_wb();
        raddr1 = 5'd1; raddr2 = 5'd31;
        #1;
        checks++; if (rdata1 !== 32'h1) begin failures++; $display("FAIL pre_rst_r1 got=%h exp=%h", rdata1, 32'h1); end
        checks++; if (rdata2 !== 32'h1F) begin failures++; $display("FAIL pre_rst_r31 got=%h exp=%h", rdata2, 32'h1F); end
        checks++; if (hi_o !== 32'h5) begin failures++; $display("FAIL pre_rst_hi got=%h exp=%h", hi_o, 32'h5); end
        tick();
        wb_wreg = 1'b1; wb_wd = 5'd2; wb_wdata = 32'h0000_0022;
        wb_whilo = 1'b1; wb_hi = 32'h0000_0077; wb_lo = 32'h0000_0066;
        raddr1 = 5'd2;
        #1;
        rst = 1'b0;  // mid-cycle, no clock edge
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL rst_drop_rdata1 got=%h exp=%h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL rst_drop_rdata2 got=%h exp=%h", rdata2, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL rst_drop_hi got=%h exp=%h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL rst_drop_lo got=%h exp=%h", lo_o, 32'h0); end
        tick();
        idle_wb();
        #1;
        rst = 1'b1;
        #1;
        raddr1 = 5'd1; raddr2 = 5'd31;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL post_rst_r1 got=%h exp=%h", rdata1, 32'h0); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL post_rst_r31 got=%h exp=%h", rdata2, 32'h0); end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL post_rst_hi got=%h exp=%h", hi_o, 32'h0); end
        checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL post_rst_lo got=%h exp=%h", lo_o, 32'h0); end
        raddr1 = 5'd2;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL dropped_write got=%h exp=%h", rdata1, 32'h0); end
        // first write after release commits at the next edge
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h0000_0777;
        tick();
        idle_wb();
        raddr1 = 5'd7;
        #1;
        checks++; if (rdata1 !== 32'h0000_0777) begin failures++; $display("FAIL first_write_after_rst got=%h exp=%h", rdata1, 32'h777); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_hilo();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
